// File: rtl/muldiv_seq.sv
// Iterative mult/multu/div/divu sequencer that owns the HI/LO registers; also services mthi/mtlo.
// Latency: mult/div write HI/LO 33 edges after accept (done pulses the next cycle); mthi/mtlo write on the accept edge.
// Backpressure: busy stalls the core; start is ignored while busy and must be re-presented.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  // acc_q: upper product half (mult) or partial remainder (div).
  // low_q: multiplier being shifted out (mult) or dividend/quotient (div).
  logic [31:0] acc_q, acc_d;
  logic [31:0] low_q, low_d;
  logic [31:0] opb_q;
  logic [31:0] araw_q;
  logic [31:0] hi_q, lo_q;
  logic        is_div_q, neg_res_q, neg_rem_q, div0_q;
  logic        busy_q, done_q;

  logic        is_signed;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum, div_shift, div_trial;
  logic [63:0] prod, prod_neg;
  logic [31:0] fix_hi, fix_lo;

  // Magnitudes of the incoming operands for signed ops; raw operands otherwise.
  always_comb begin
    is_signed = (funct == F_MULT) || (funct == F_DIV);
    abs_a     = (is_signed && a[31]) ? (~a + 32'd1) : a;
    abs_b     = (is_signed && b[31]) ? (~b + 32'd1) : b;
  end

  // One shift-add or restoring-divide iteration.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opb_q} : 33'd0);
    div_shift = {acc_q, low_q[31]};
    div_trial = div_shift - {1'b0, opb_q};
    if (is_div_q) begin
      if (!div_trial[32]) begin
        acc_d = div_trial[31:0];
        low_d = {low_q[30:0], 1'b1};
      end else begin
        acc_d = div_shift[31:0];
        low_d = {low_q[30:0], 1'b0};
      end
    end else begin
      acc_d = mul_sum[32:1];
      low_d = {mul_sum[0], low_q[31:1]};
    end
  end

  // Sign correction and divide-by-zero override applied at writeback.
  always_comb begin
    prod     = {acc_q, low_q};
    prod_neg = ~prod + 64'd1;
    fix_hi   = prod[63:32];
    fix_lo   = prod[31:0];
    if (is_div_q) begin
      if (div0_q) begin
        fix_hi = araw_q;
        fix_lo = 32'hFFFF_FFFF;
      end else begin
        fix_lo = neg_res_q ? (~low_q + 32'd1) : low_q;
        fix_hi = neg_rem_q ? (~acc_q + 32'd1) : acc_q;
      end
    end else if (neg_res_q) begin
      fix_hi = prod_neg[63:32];
      fix_lo = prod_neg[31:0];
    end
  end

  // Sequencer FSM with registered busy/done/HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 32'd0;
      low_q     <= 32'd0;
      opb_q     <= 32'd0;
      araw_q    <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            case (funct)
              F_MTHI: hi_q <= a;
              F_MTLO: lo_q <= a;
              F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                state_q   <= S_CALC;
                busy_q    <= 1'b1;
                cnt_q     <= 5'd0;
                acc_q     <= 32'd0;
                is_div_q  <= funct[1];
                low_q     <= funct[1] ? abs_a : abs_b;
                opb_q     <= funct[1] ? abs_b : abs_a;
                araw_q    <= a;
                neg_res_q <= is_signed && (a[31] ^ b[31]);
                neg_rem_q <= is_signed && a[31];
                div0_q    <= (b == 32'd0);
              end
              default: ;
            endcase
          end
        end
        S_CALC: begin
          if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= 5'd0;
          end else begin
            acc_q <= acc_d;
            low_q <= low_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= 5'd0;
          if (!flush) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer owning the HI/LO special registers of the MIPS core. It accepts mult, multu, div, divu, mthi and mtlo operations from the decode stage and runs multiplies and divides over 32 iterations. While an operation is in flight it asserts `busy`, which the core uses as a stall. It also exposes HI/LO directly for mfhi/mflo.

## Interface
- Parameters: none; fixed 32-bit datapath, 32 iterations.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request valid this cycle; sampled on the rising edge.
- `funct`  in  6  R-type funct: 24 mult, 25 multu, 26 div, 27 divu, 17 mthi, 19 mtlo; all other values ignored.
- `a`  in  32  rs operand (multiplicand, dividend, or mthi/mtlo source).
- `b`  in  32  rt operand (multiplier or divisor).
- `flush`  in  1  cancel any in-flight mult/div.
- `busy`  out  1  mult/div in progress; the core stalls on it.
- `done`  out  1  one-cycle pulse on the cycle after HI/LO are written by mult/div.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States:
  - IDLE: accepts work.
  - CALC: iterations; a 5-bit counter runs 0..31.
  - FIX: sign correction, divide-by-zero override, HI/LO writeback.
- IDLE with `start` and funct 24..27:
  - Captures |a| and |b| for signed ops, raw a and b for unsigned ops.
  - Records the result sign and the dividend sign.
  - Clears the accumulator and enters CALC.
- IDLE with `start` and funct 17: `hi <= a`. Funct 19: `lo <= a`. No busy, no done.
- Multiply uses a shift-add over a 64-bit product register, one bit of the multiplier per cycle.
- Divide uses restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
- FIX for mult/multu: writes {hi, lo} = product, negated in 64-bit two's complement if the result sign is set.
- FIX for div/divu:
  - Quotient goes to `lo`; negated if sign(a) XOR sign(b) for div.
  - Remainder goes to `hi`; negated if sign(a) for div, so the remainder takes the dividend's sign.
- Divide by zero (b == 0, either signedness): `lo = 32'hFFFF_FFFF`, `hi = a` (raw operand).
- div 0x80000000 / 0xFFFFFFFF: `lo = 32'h8000_0000`, `hi = 0` (two's-complement wrap; no trap).
- `start` while busy: ignored, including mthi/mtlo. The stall guarantees the core re-presents the request.
- `flush` in CALC or FIX: return to IDLE next edge; HI/LO unchanged; no done pulse.
- `flush` in IDLE: no effect; a simultaneous `start` is dropped.
- Operands are captured at accept; later changes on `a`/`b` have no effect.

## Timing
- Reset (async, `reset_n` low):
  - State goes to IDLE; counter = 0.
  - `busy = 0`, `done = 0`, `hi = 0`, `lo = 0`.
  - Applies immediately, mid-operation included.
- Accept edge E0: `busy = 1` from E0 until E33.
- CALC occupies edges E1..E32.
- FIX edge E33: HI/LO written, `busy` falls to 0, `done = 1` for the cycle following E33.
- Total: 33 cycles from accept to HI/LO update.
- A new `start` is accepted on the same edge that `done` is high: back-to-back issue, so the next op's E0 is E34.
- mthi/mtlo: register updated on the accept edge; `busy` stays 0.
- `hi`/`lo` are registered outputs. They hold old values throughout CALC, so mfhi during a stall reads the pre-op values.
- `busy` and `done` are registered; no combinational path from inputs to outputs.

## Test plan
- multu a=0xFFFFFFFF, b=0xFFFFFFFF:
  - `busy` is high for 33 cycles.
  - Then hi=0xFFFFFFFE, lo=0x00000001, with a single-cycle `done`.
- mult a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
- div boundaries:
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - divu 0xFFFFFFFF/0x10 -> lo=0x0FFFFFFF, hi=0xF.
- Control:
  - mthi a=0x1234 in IDLE -> hi=0x1234 next edge, busy stays 0.
  - mthi during busy -> ignored.
  - flush at iteration 10 -> IDLE, HI/LO unchanged, no done.
  - `reset_n` low at iteration 20 -> all outputs 0 immediately.
